seq_muldiv: RTL and testbench

Parametrised multi-cycle integer multiply/divide unit for the CPU datapath, feeding the HI/LO registers. Supports signed and unsigned multiplication (shift-add, one bit per cycle) and signed and unsigned division (restoring, one bit per cycle). Uses a start/busy/done handshake so the control unit can stall on it, and flags division by zero.

---
 rtl/seq_muldiv_if.sv | 15 +
 rtl/seq_muldiv.sv | 112 +++++++++++
 tb/tb_seq_muldiv.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_muldiv_if.sv
// Handshake/operand bundle for the multi-cycle multiply/divide unit.
interface seq_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (output start, op, a, b, input hi, lo, busy, done, div_zero);
  modport slave  (input start, op, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/seq_muldiv.sv
// Multi-cycle integer multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Signed ops run on magnitudes; signs are reapplied in the FIX state.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      reset,
  seq_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_res, neg_rem, dz_pend;
  logic [WIDTH-1:0]   a_raw, mag_a, mag_b, quo;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] addend, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    a_neg    = bus.op[0] & bus.a[WIDTH-1];
    b_neg    = bus.op[0] & bus.b[WIDTH-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
    // Dividend is shifted out MSB first through mag_a during divides.
    rem_sh   = {rem[WIDTH-1:0], mag_a[WIDTH-1]};
    diff     = {1'b0, rem_sh} - {2'b00, mag_b};
    addend   = mag_b[cnt] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0;
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -quo : quo;
    rem_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      is_div       <= 1'b0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      dz_pend      <= 1'b0;
      a_raw        <= '0;
      mag_a        <= '0;
      mag_b        <= '0;
      quo          <= '0;
      acc          <= '0;
      rem          <= '0;
      bus.hi       <= '0;
      bus.lo       <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            is_div       <= bus.op[1];
            a_raw        <= bus.a;
            mag_a        <= a_mag;
            mag_b        <= b_mag;
            neg_res      <= a_neg ^ b_neg;
            neg_rem      <= a_neg;
            acc          <= '0;
            rem          <= '0;
            quo          <= '0;
            cnt          <= '0;
            bus.div_zero <= 1'b0;
            bus.busy     <= 1'b1;
            dz_pend      <= bus.op[1] && (bus.b == '0);
            state        <= (bus.op[1] && (bus.b == '0)) ? FIX : CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            mag_a <= mag_a << 1;
            quo   <= {quo[WIDTH-2:0], ~diff[WIDTH+1]};
            rem   <= diff[WIDTH+1] ? rem_sh : diff[WIDTH:0];
          end else begin
            acc <= acc + addend;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (dz_pend) begin
            bus.hi       <= a_raw;
            bus.lo       <= '1;
            bus.div_zero <= 1'b1;
          end else if (is_div) begin
            bus.hi <= rem_fix;
            bus.lo <= quo_fix;
          end else begin
            {bus.hi, bus.lo} <= prod_fix;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_muldiv.sv
// Randomized and directed checks of seq_muldiv at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_seq_muldiv;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  seq_muldiv_if #(.WIDTH(32)) m32();
  seq_muldiv_if #(.WIDTH(8))  m8();

  seq_muldiv #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(m32.slave));
  seq_muldiv #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(m8.slave));

  int checks   = 0;
  int failures = 0;

  // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic void model(input int w, input logic [1:0] op, input logic [63:0] a_i, b_i,
                                output logic [63:0] hi, output logic [63:0] lo, output logic dz);
    logic [63:0] m, a, b, p;
    longint sa, sb;
    m  = (64'd1 << w) - 64'd1;
    a  = a_i & m;
    b  = b_i & m;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = a * b;   hi = (p >> w) & m; lo = p & m; end
      2'd1: begin p = sa * sb; hi = (p >> w) & m; lo = p & m; end
      default: begin
        if (b == 0) begin
          hi = a; lo = m; dz = 1'b1;
        end else if (op == 2'd2) begin
          lo = a / b; hi = a % b;
        end else begin
          lo = 64'(sa / sb) & m; hi = 64'(sa % sb) & m;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Drive a request now; it is accepted on the next rising edge. Inputs are scrambled afterwards.
  task automatic go32(input logic [1:0] op, input logic [31:0] a, b);
    m32.start = 1'b1; m32.op = op; m32.a = a; m32.b = b;
    tick();
    m32.start = 1'b0; m32.op = 2'($urandom_range(0, 3)); m32.a = $urandom; m32.b = $urandom;
    checks++;
    if (m32.busy !== 1'b1) begin failures++; $display("FAIL busy32_after_start got %b want 1", m32.busy); end
  endtask

  task automatic wait32(input int n0, output int n);
    n = n0;
    while (m32.done !== 1'b1 && n < 200) begin tick(); n++; end
  endtask

  task automatic check32(input string nm, input logic [1:0] op, input logic [31:0] a, b, input int n);
    logic [63:0] eh, el;
    logic ed;
    int lat;
    model(32, op, {32'd0, a}, {32'd0, b}, eh, el, ed);
    lat = (op[1] && b == 0) ? 1 : 33;
    checks++; if (n != lat) begin failures++; $display("FAIL %s latency got %0d want %0d", nm, n, lat); end
    checks++; if (m32.hi !== eh[31:0]) begin failures++; $display("FAIL %s hi got %h want %h", nm, m32.hi, eh[31:0]); end
    checks++; if (m32.lo !== el[31:0]) begin failures++; $display("FAIL %s lo got %h want %h", nm, m32.lo, el[31:0]); end
    checks++; if (m32.div_zero !== ed) begin failures++; $display("FAIL %s div_zero got %b want %b", nm, m32.div_zero, ed); end
    checks++; if (m32.busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got %b want 0", nm, m32.busy); end
  endtask

  task automatic run32(input string nm, input logic [1:0] op, input logic [31:0] a, b);
    int n;
    @(negedge clock);
    go32(op, a, b);
    wait32(0, n);
    check32(nm, op, a, b, n);
  endtask

  task automatic lit32(input string nm, input logic [31:0] hi, lo);
    checks++;
    if (m32.hi !== hi || m32.lo !== lo) begin
      failures++; $display("FAIL %s_const got %h_%h want %h_%h", nm, m32.hi, m32.lo, hi, lo);
    end
  endtask

  task automatic run8(input string nm, input logic [1:0] op, input logic [7:0] a, b);
    logic [63:0] eh, el;
    logic ed;
    int n, lat;
    @(negedge clock);
    m8.start = 1'b1; m8.op = op; m8.a = a; m8.b = b;
    tick();
    m8.start = 1'b0; m8.a = 8'($urandom); m8.b = 8'($urandom);
    n = 0;
    while (m8.done !== 1'b1 && n < 100) begin tick(); n++; end
    model(8, op, {56'd0, a}, {56'd0, b}, eh, el, ed);
    lat = (op[1] && b == 0) ? 1 : 9;
    checks++; if (n != lat) begin failures++; $display("FAIL %s latency got %0d want %0d", nm, n, lat); end
    checks++; if (m8.hi !== eh[7:0]) begin failures++; $display("FAIL %s hi got %h want %h", nm, m8.hi, eh[7:0]); end
    checks++; if (m8.lo !== el[7:0]) begin failures++; $display("FAIL %s lo got %h want %h", nm, m8.lo, el[7:0]); end
    checks++; if (m8.div_zero !== ed) begin failures++; $display("FAIL %s div_zero got %b want %b", nm, m8.div_zero, ed); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m32.start = 1'b0; m32.op = '0; m32.a = '0; m32.b = '0;
    m8.start = 1'b0;  m8.op = '0;  m8.a = '0;  m8.b = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({m32.hi, m32.lo, m32.busy, m32.done, m32.div_zero} !== '0) begin
      failures++; $display("FAIL reset32 got %h_%h %b%b%b want zeros", m32.hi, m32.lo, m32.busy, m32.done, m32.div_zero);
    end
    checks++;
    if ({m8.hi, m8.lo, m8.busy, m8.done, m8.div_zero} !== '0) begin
      failures++; $display("FAIL reset8 got %h_%h %b%b%b want zeros", m8.hi, m8.lo, m8.busy, m8.done, m8.div_zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run32("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF); lit32("multu_max", 32'hFFFFFFFE, 32'h00000001);
    run32("mult_neg", 2'd1, 32'hFFFFFFFD, 32'd5);         lit32("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);
    run32("multu_neg", 2'd0, 32'hFFFFFFFD, 32'd5);        lit32("multu_neg", 32'h00000004, 32'hFFFFFFF1);
    run32("div_neg", 2'd3, 32'hFFFFFFF9, 32'd2);          lit32("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run32("divu", 2'd2, 32'd7, 32'd2);                    lit32("divu", 32'd1, 32'd3);
    run32("div_minneg", 2'd3, 32'h80000000, 32'hFFFFFFFF); lit32("div_minneg", 32'd0, 32'h80000000);
    run32("divu_zero", 2'd2, 32'd7, 32'd0);               lit32("divu_zero", 32'd7, 32'hFFFFFFFF);
  endtask

  task automatic test_dz_clear();
    int n;
    @(negedge clock);
    go32(2'd0, 32'd6, 32'd7);
    checks++; if (m32.div_zero !== 1'b0) begin failures++; $display("FAIL dz_clear got %b want 0", m32.div_zero); end
    checks++; if (m32.hi !== 32'd7) begin failures++; $display("FAIL dz_hold_hi got %h want 7", m32.hi); end
    wait32(0, n);
    check32("after_dz", 2'd0, 32'd6, 32'd7, n);
  endtask

  task automatic test_random32();
    logic [1:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 25; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = $urandom_range(1, 100);
        default: ;
      endcase
      run32("rand32", op, a, b);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    @(negedge clock);
    go32(2'd1, 32'h12345678, 32'hFEDCBA98);
    repeat (3) tick();
    m32.start = 1'b1; m32.op = 2'd2; m32.a = 32'd99; m32.b = 32'd0;
    tick();
    m32.start = 1'b0;
    wait32(4, n);
    check32("ignore_start", 2'd1, 32'h12345678, 32'hFEDCBA98, n);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] h1, l1;
    @(negedge clock);
    go32(2'd3, 32'hDEADBEEF, 32'h00001234);
    wait32(0, n);
    check32("b2b_first", 2'd3, 32'hDEADBEEF, 32'h00001234, n);
    h1 = m32.hi; l1 = m32.lo;
    go32(2'd0, 32'hCAFEF00D, 32'h0BADC0DE);
    checks++; if (m32.done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got %b want 0", m32.done); end
    checks++; if (m32.hi !== h1 || m32.lo !== l1) begin failures++; $display("FAIL b2b_hold got %h_%h want %h_%h", m32.hi, m32.lo, h1, l1); end
    wait32(0, n);
    check32("b2b_second", 2'd0, 32'hCAFEF00D, 32'h0BADC0DE, n);
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clock);
    go32(2'd0, 32'hFFFFFFFF, 32'h7FFFFFFF);
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({m32.hi, m32.lo, m32.busy, m32.done, m32.div_zero} !== '0) begin
      failures++; $display("FAIL reset_mid got %h_%h %b%b%b want zeros", m32.hi, m32.lo, m32.busy, m32.done, m32.div_zero);
    end
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (m32.done === 1'b1) dones++; end
    checks++; if (dones != 0) begin failures++; $display("FAIL reset_mid_done got %0d want 0", dones); end
  endtask

  task automatic test_width8();
    run8("w8_multu", 2'd0, 8'hFF, 8'hFF);
    run8("w8_mult", 2'd1, 8'hFD, 8'd5);
    run8("w8_div", 2'd3, 8'hF9, 8'd2);
    run8("w8_divu", 2'd2, 8'd7, 8'd2);
    run8("w8_minneg", 2'd3, 8'h80, 8'hFF);
    run8("w8_dz", 2'd2, 8'd7, 8'd0);
    for (int i = 0; i < 20; i++)
      run8("w8_rand", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 255)));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_dz_clear();
    test_random32();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
